// File: rtl/anc_spi_pkg.sv
// Shared widths and the assembler state type for the SPI sample path.
package anc_spi_pkg;

  localparam int BYTE_W   = 8;
  localparam int SAMPLE_W = 16;

  typedef enum logic {
    WAIT_HI = 1'b0,
    WAIT_LO = 1'b1
  } asm_state_e;

endpackage : anc_spi_pkg

// File: rtl/sample_fifo.sv
// First-word-fall-through sample FIFO with an occupancy counter that separates full from empty.
module sample_fifo #(
  parameter int DEPTH    = 8,
  parameter int SAMPLE_W = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push_i,
  input  logic [SAMPLE_W-1:0]        push_data_i,
  input  logic                       pop_i,
  output logic [SAMPLE_W-1:0]        head_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     level_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [SAMPLE_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]    count_q, count_d;
  logic                push_ok, pop_ok;

  assign full_o  = (count_q == LVL_W'(DEPTH));
  assign empty_o = (count_q == '0);

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign pop_ok  = pop_i & ~empty_o;
  assign push_ok = push_i & (~full_o | pop_ok);

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    unique case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + LVL_W'(1);
      2'b01:   count_d = count_q - LVL_W'(1);
      default: count_d = count_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is not reset; the pointers and count alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data_i;
  end

  // Head is forced to zero when empty so stale storage never shows on the output.
  assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q];
  assign level_o = count_q;

endmodule : sample_fifo

// File: rtl/spi_sample_assembler.sv
// Pairs SPI bytes (high then low) into signed samples and queues them for a consumer.
module spi_sample_assembler #(
  parameter int DEPTH    = 8,
  parameter int SAMPLE_W = anc_spi_pkg::SAMPLE_W
) (
  input  logic                          Clk,
  input  logic                          Rst_n,
  input  logic                          SS,
  input  logic                          Byte_Valid,
  input  logic [anc_spi_pkg::BYTE_W-1:0] Byte_In,
  output logic [SAMPLE_W-1:0]           Sample_Data,
  output logic                          Sample_Valid,
  input  logic                          Sample_Ready,
  output logic [$clog2(DEPTH):0]        Level,
  output logic                          Overflow,
  input  logic                          Ovf_Clr
);

  import anc_spi_pkg::*;

  asm_state_e        state_q, state_d;
  logic [BYTE_W-1:0] hi_q, hi_d;
  logic              push;
  logic              fifo_full, fifo_empty;
  logic              pop_ok, drop;
  logic              ovf_q, ovf_d;

  // Deselect wins over a same-cycle strobe and throws away any half-built sample.
  always_comb begin
    state_d = state_q;
    hi_d    = hi_q;
    push    = 1'b0;
    if (SS) begin
      state_d = WAIT_HI;
      hi_d    = '0;
    end else if (Byte_Valid) begin
      unique case (state_q)
        WAIT_HI: begin
          hi_d    = Byte_In;
          state_d = WAIT_LO;
        end
        WAIT_LO: begin
          push    = 1'b1;
          state_d = WAIT_HI;
        end
        default: state_d = WAIT_HI;
      endcase
    end
  end

  assign pop_ok = Sample_Ready & ~fifo_empty;
  assign drop   = push & fifo_full & ~pop_ok;
  // A new drop outranks a clear arriving in the same cycle.
  assign ovf_d  = drop | (ovf_q & ~Ovf_Clr);

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= WAIT_HI;
      hi_q    <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      ovf_q   <= ovf_d;
    end
  end

  sample_fifo #(
    .DEPTH    (DEPTH),
    .SAMPLE_W (SAMPLE_W)
  ) u_fifo (
    .clk         (Clk),
    .rst_n       (Rst_n),
    .push_i      (push),
    .push_data_i ({hi_q, Byte_In}),
    .pop_i       (Sample_Ready),
    .head_o      (Sample_Data),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .level_o     (Level)
  );

  assign Sample_Valid = ~fifo_empty;
  assign Overflow     = ovf_q;

endmodule : spi_sample_assembler

// File: doc/spi_sample_assembler.md
SPI_SAMPLE_ASSEMBLER -- requirements
Module: spi_sample_assembler

Interface
REQ-001 Parameter DEPTH, default 8, sample FIFO depth in entries; power of two, 2..64.
REQ-002 Parameter SAMPLE_W, default 16, sample width; fixed at 2 x byte width.
REQ-003 Clk  input  1  sole clock; all logic on rising edge.
REQ-004 Rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SS  input  1  SPI slave select, active-low; high = no frame in progress; synchronous to Clk.
REQ-006 Byte_Valid  input  1  one-cycle strobe: a received byte is present on Byte_In; Clk-synchronous SSPIF from the SPI slave stage.
REQ-007 Byte_In  input  8  received byte; bit 7 = first bit shifted in.
REQ-008 Sample_Data  output  SAMPLE_W  FIFO head sample, signed two's complement.
REQ-009 Sample_Valid  output  1  FIFO non-empty; Sample_Data is meaningful.
REQ-010 Sample_Ready  input  1  consumer accepts head when high together with Sample_Valid.
REQ-011 Level  output  clog2(DEPTH)+1  current FIFO occupancy.
REQ-012 Overflow  output  1  sticky: a completed sample was dropped.
REQ-013 Ovf_Clr  input  1  one-cycle pulse clearing Overflow.

Function
REQ-014 The assembler SHALL have two states: WAIT_HI and WAIT_LO.
REQ-015 In WAIT_HI with SS low, Byte_Valid SHALL latch Byte_In as the high byte and move to WAIT_LO.
REQ-016 In WAIT_LO with SS low, Byte_Valid SHALL form {high byte, Byte_In}, request a FIFO push, and return to WAIT_HI.
REQ-017 SS high SHALL force WAIT_HI and discard any latched high byte; SS high takes priority over a same-cycle Byte_Valid, which is ignored.
REQ-018 Each cycle with Byte_Valid high SHALL count as one byte; no deglitching of the strobe.
REQ-019 A pushed sample SHALL appear on Sample_Data with Sample_Valid high in the cycle after the low-byte strobe (latency 1), if the FIFO was empty.
REQ-020 The FIFO SHALL be first-word-fall-through and strictly in order; Sample_Data SHALL hold stable while Sample_Valid high and Sample_Ready low.
REQ-021 A pop SHALL occur when Sample_Valid and Sample_Ready are both high; Sample_Ready with FIFO empty SHALL have no effect.
REQ-022 A push when Level = DEPTH and no same-cycle pop SHALL drop the new sample, leave FIFO contents and Level unchanged, and set Overflow the next cycle.
REQ-023 A push and pop in the same cycle at Level = DEPTH SHALL both succeed; Level stays DEPTH; Overflow unaffected.
REQ-024 A push and pop in the same cycle at 0 < Level < DEPTH SHALL leave Level unchanged.
REQ-025 Pointers SHALL wrap modulo DEPTH; Level SHALL distinguish full (DEPTH) from empty (0).
REQ-026 Ovf_Clr coinciding with a new overflow event SHALL leave Overflow set (set wins).
REQ-027 Level SHALL update the cycle after the push/pop that changes it.

Reset
REQ-028 Rst_n low SHALL immediately force: state WAIT_HI, high-byte register 0, FIFO empty, Level 0, Sample_Valid 0, Sample_Data 0, Overflow 0.
REQ-029 Reset asserted mid-sample or mid-burst SHALL discard the partial sample and all FIFO contents; no samples are emitted after release until two new bytes arrive with SS low.
REQ-030 FIFO storage array need not be reset; only its pointers and flags are.

Structure
REQ-031 Shared package anc_spi_pkg SHALL hold BYTE_W = 8, SAMPLE_W = 16 and the assembler state type.
REQ-032 FIFO SHALL be a separate sub-module sample_fifo (parameters DEPTH, SAMPLE_W; push/pop/full/empty/level ports); the assembler FSM stays in the top.

Verification
REQ-033 SS low, bytes 0x12 then 0x34 -> one cycle later Sample_Valid = 1, Sample_Data = 0x1234, Level = 1.
REQ-034 SS low, byte 0xAB, SS high one cycle, SS low, bytes 0x80, 0x01 -> only sample 0x8001 (-32767) emitted; 0xAB discarded.
REQ-035 Sample_Ready = 0, push DEPTH+1 samples 0x0000..0x0008 -> Level = 8, Overflow = 1, pops return 0x0000..0x0007 in order, 0x0008 absent.
REQ-036 FIFO full, Sample_Ready = 1 on the cycle of a low-byte strobe -> Level stays 8, Overflow stays 0, new sample at tail.
REQ-037 Rst_n pulsed low between high and low bytes with 3 samples queued -> Level = 0, Sample_Valid = 0 at once; next byte pair forms a fresh sample.
REQ-038 Overflow set, Ovf_Clr pulsed in the same cycle as another dropped push -> Overflow remains 1; Ovf_Clr alone -> Overflow = 0 next cycle.
